// File: rtl/clus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : clus_ctrl_pkg
//  Purpose : Shared types for the cluster sequencer: the FSM state encoding
//            and a helper that sizes counters from their maximum count.
//  Rev     : 1.0  initial release
// ============================================================================
package clus_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_W  = 4'd1,
    LOAD_I  = 4'd2,
    SPAD_W  = 4'd3,
    SPAD_I  = 4'd4,
    KICK    = 4'd5,
    COMPUTE = 4'd6,
    DRAIN   = 4'd7,
    READ    = 4'd8
  } state_t;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clus_ctrl_rdbuf.sv
`default_nettype none
// ============================================================================
//  Module  : clus_ctrl_rdbuf
//  Purpose : Psum readout engine. Issues GLB psum reads and holds each
//            returned word in a single-entry output register with
//            valid/ready. One read is outstanding at most; a new read is
//            issued only when the output register is (or is about to be)
//            empty.
//  Ports   : clk, rst          - clock, synchronous active-high reset
//            i_en              - readout phase active; low clears the count
//            o_read_req/addr   - GLB psum read request and address
//            i_read_data       - GLB psum data, valid 1 cycle after request
//            o_out_valid/data  - output word register
//            i_out_ready       - downstream accept
//            o_last_acc        - accept of the final psum word (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module clus_ctrl_rdbuf
  import clus_ctrl_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int PSUM_CNT      = 100,
  parameter int PSUM_GLB_BASE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  output logic                     o_read_req,
  output logic [ADDR_BITWIDTH-1:0] o_read_addr,
  input  logic [DATA_BITWIDTH-1:0] i_read_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_BITWIDTH-1:0] o_out_data,
  output logic                     o_last_acc
);

  localparam int c_RCNT_W = cnt_width(PSUM_CNT);

  logic [c_RCNT_W-1:0]      r_rcnt;
  logic                     r_read_req;
  logic                     r_pend;      // GLB data arrives this cycle
  logic [ADDR_BITWIDTH-1:0] r_read_addr;
  logic                     r_out_valid;
  logic [DATA_BITWIDTH-1:0] r_out_data;

  logic                w_acc;
  logic                w_last_acc;
  logic                w_issue;
  logic [c_RCNT_W-1:0] w_rcnt_nxt;

  assign w_acc      = r_out_valid & i_out_ready;
  assign w_last_acc = w_acc && (r_rcnt == c_RCNT_W'(PSUM_CNT - 1));
  assign w_rcnt_nxt = w_acc ? (r_rcnt + c_RCNT_W'(1)) : r_rcnt;

  // The accept of a non-final word frees the register on this edge, so the
  // next read may be issued alongside it. After the final word nothing more
  // is read.
  assign w_issue = i_en && !r_read_req && !r_pend &&
                   (!r_out_valid || (w_acc && !w_last_acc));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt      <= '0;
      r_read_req  <= 1'b0;
      r_pend      <= 1'b0;
      r_read_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_read_req <= w_issue;
      if (w_issue) begin
        r_read_addr <= ADDR_BITWIDTH'(PSUM_GLB_BASE) + ADDR_BITWIDTH'(w_rcnt_nxt);
      end
      r_pend <= r_read_req;
      if (r_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_read_data;
      end else if (w_acc) begin
        r_out_valid <= 1'b0;
      end
      r_rcnt <= i_en ? w_rcnt_nxt : '0;
    end
  end

  assign o_read_req  = r_read_req;
  assign o_read_addr = r_read_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_last_acc  = w_last_acc;

endmodule
`default_nettype wire

// File: rtl/clus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : clus_ctrl
//  Purpose : Layer-job sequencer for the cluster top. Streams weights then
//            iacts into the GLB, requests spad loads, pulses start, waits for
//            compute done plus a drain delay, then streams final psums out.
//  Ports   : clk, reset                         - clock, sync active-high reset
//            job_start / busy / job_done        - job control
//            in_valid / in_ready / in_data      - input word stream
//            write_en_* / w_addr_* / w_data_*   - GLB weight/iact writes
//            load_spad_ctrl_* / load_done_*     - spad load handshake
//            start / write_psum_ctrl            - PE start, compute done
//            read_req_psum / r_addr_psum / r_data_psum - GLB psum read
//            out_valid / out_ready / out_data   - psum output stream
//            perf_cycles                        - busy-cycle counter
//  Config  : CLUS_CTRL_PERF_EN adds perf_cycles (clears on job accept,
//            counts busy cycles, saturates).
//  Rev     : 1.0  initial release
// ============================================================================
module clus_ctrl
  import clus_ctrl_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int kernel_size   = 3,
  parameter int act_size      = 12,
  parameter int PSUM_CNT      = 100,
  parameter int W_GLB_BASE    = 0,
  parameter int A_GLB_BASE    = 0,
  parameter int PSUM_GLB_BASE = 0,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_start,
  output logic                     busy,
  output logic                     job_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     write_en_wght,
  output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
  output logic [DATA_BITWIDTH-1:0] w_data_wght,
  output logic                     write_en_iact,
  output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
  output logic [DATA_BITWIDTH-1:0] w_data_iact,
  output logic                     load_spad_ctrl_wght,
  output logic                     load_spad_ctrl_iact,
  input  logic                     load_done_wght,
  input  logic                     load_done_iact,
  output logic                     start,
  input  logic                     write_psum_ctrl,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data
`ifdef CLUS_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_cycles
`endif
);

  localparam int c_W_CNT  = kernel_size * kernel_size;
  localparam int c_A_CNT  = act_size * act_size;
  localparam int c_LCNT_W = cnt_width((c_W_CNT > c_A_CNT) ? c_W_CNT : c_A_CNT);
  localparam int c_DCNT_W = cnt_width(DRAIN_CYCLES + 1);

  state_t              r_state, w_state_nxt;
  logic [c_LCNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [c_DCNT_W-1:0] r_dcnt, w_dcnt_nxt;

  logic                     r_busy, r_job_done, r_in_ready;
  logic                     r_wen_w, r_wen_i;
  logic [ADDR_BITWIDTH-1:0] r_waddr_w, r_waddr_i;
  logic [DATA_BITWIDTH-1:0] r_wdata_w, r_wdata_i;
  logic                     r_ld_w, r_ld_i, r_start;

  logic w_hs;
  logic w_job_acc;
  logic w_last_acc;
  logic w_rd_en;

  // in_ready is only ever high in the two load states, so it doubles as the
  // load-phase qualifier for the handshake.
  assign w_hs      = in_valid & r_in_ready;
  assign w_job_acc = (r_state == IDLE) && job_start;
  assign w_rd_en   = (r_state == READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      IDLE: begin
        if (job_start) begin
          w_state_nxt = LOAD_W;
          w_cnt_nxt   = '0;
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          if (r_cnt == c_LCNT_W'(c_W_CNT - 1)) begin
            w_state_nxt = LOAD_I;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_LCNT_W'(1);
          end
        end
      end
      LOAD_I: begin
        if (w_hs) begin
          if (r_cnt == c_LCNT_W'(c_A_CNT - 1)) begin
            w_state_nxt = SPAD_W;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_LCNT_W'(1);
          end
        end
      end
      SPAD_W:  if (load_done_wght) w_state_nxt = SPAD_I;
      SPAD_I:  if (load_done_iact) w_state_nxt = KICK;
      KICK:    w_state_nxt = COMPUTE;
      COMPUTE: begin
        if (write_psum_ctrl) begin
          w_state_nxt = DRAIN;
          w_dcnt_nxt  = c_DCNT_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (r_dcnt == '0) w_state_nxt = READ;
        else              w_dcnt_nxt  = r_dcnt - c_DCNT_W'(1);
      end
      READ:    if (w_last_acc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Level-type outputs are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_job_done <= 1'b0;
      r_in_ready <= 1'b0;
      r_wen_w    <= 1'b0;
      r_waddr_w  <= '0;
      r_wdata_w  <= '0;
      r_wen_i    <= 1'b0;
      r_waddr_i  <= '0;
      r_wdata_i  <= '0;
      r_ld_w     <= 1'b0;
      r_ld_i     <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != IDLE);
      r_in_ready <= (w_state_nxt == LOAD_W) || (w_state_nxt == LOAD_I);
      r_ld_w     <= (w_state_nxt == SPAD_W);
      r_ld_i     <= (w_state_nxt == SPAD_I);
      r_start    <= (w_state_nxt == KICK);
      r_job_done <= w_last_acc;

      r_wen_w <= (r_state == LOAD_W) && w_hs;
      if ((r_state == LOAD_W) && w_hs) begin
        r_waddr_w <= ADDR_BITWIDTH'(W_GLB_BASE) + ADDR_BITWIDTH'(r_cnt);
        r_wdata_w <= in_data;
      end
      r_wen_i <= (r_state == LOAD_I) && w_hs;
      if ((r_state == LOAD_I) && w_hs) begin
        r_waddr_i <= ADDR_BITWIDTH'(A_GLB_BASE) + ADDR_BITWIDTH'(r_cnt);
        r_wdata_i <= in_data;
      end
    end
  end

  clus_ctrl_rdbuf #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .ADDR_BITWIDTH (ADDR_BITWIDTH),
    .PSUM_CNT      (PSUM_CNT),
    .PSUM_GLB_BASE (PSUM_GLB_BASE)
  ) u_rdbuf (
    .clk         (clk),
    .rst         (reset),
    .i_en        (w_rd_en),
    .o_read_req  (read_req_psum),
    .o_read_addr (r_addr_psum),
    .i_read_data (r_data_psum),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_last_acc  (w_last_acc)
  );

`ifdef CLUS_CTRL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (w_job_acc) begin
      r_perf <= '0;
    end else if ((r_state != IDLE) && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  logic w_unused_acc;
  assign w_unused_acc = w_job_acc;
`endif

  assign busy                = r_busy;
  assign job_done            = r_job_done;
  assign in_ready            = r_in_ready;
  assign write_en_wght       = r_wen_w;
  assign w_addr_wght         = r_waddr_w;
  assign w_data_wght         = r_wdata_w;
  assign write_en_iact       = r_wen_i;
  assign w_addr_iact         = r_waddr_i;
  assign w_data_iact         = r_wdata_i;
  assign load_spad_ctrl_wght = r_ld_w;
  assign load_spad_ctrl_iact = r_ld_i;
  assign start               = r_start;

endmodule
`default_nettype wire

// File: tb/tb_clus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_clus_ctrl
//  Purpose : Self-checking bench for clus_ctrl. A reactive driver feeds
//            random job words, spad load acknowledges, compute done and
//            random output back-pressure; a behavioural model predicts the
//            GLB write/read address sequences and psum output data. A second
//            instance with W_GLB_BASE=1020 checks address wrap.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_clus_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int NW    = 9;
  localparam int NA    = 144;
  localparam int NP    = 100;
  localparam int DRAIN = 4;
  localparam int WB2   = 1020;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, job_start, in_valid, load_done_wght, load_done_iact;
  logic          write_psum_ctrl, out_ready;
  logic [DW-1:0] in_data, r_data_psum;

  logic          busy, job_done, in_ready, write_en_wght, write_en_iact;
  logic [AW-1:0] w_addr_wght, w_addr_iact, r_addr_psum;
  logic [DW-1:0] w_data_wght, w_data_iact, out_data;
  logic          load_spad_ctrl_wght, load_spad_ctrl_iact, start, read_req_psum, out_valid;

  logic          busy_b, job_done_b, in_ready_b, write_en_wght_b, write_en_iact_b;
  logic [AW-1:0] w_addr_wght_b, w_addr_iact_b, r_addr_psum_b;
  logic [DW-1:0] w_data_wght_b, w_data_iact_b, out_data_b;
  logic          load_spad_ctrl_wght_b, load_spad_ctrl_iact_b, start_b, read_req_psum_b, out_valid_b;
`ifdef CLUS_CTRL_PERF_EN
  logic [31:0]   perf_cycles, perf_cycles_b;
`endif

  clus_ctrl dut (
    .clk(clk), .reset(reset), .job_start(job_start), .busy(busy), .job_done(job_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .write_en_wght(write_en_wght), .w_addr_wght(w_addr_wght), .w_data_wght(w_data_wght),
    .write_en_iact(write_en_iact), .w_addr_iact(w_addr_iact), .w_data_iact(w_data_iact),
    .load_spad_ctrl_wght(load_spad_ctrl_wght), .load_spad_ctrl_iact(load_spad_ctrl_iact),
    .load_done_wght(load_done_wght), .load_done_iact(load_done_iact),
    .start(start), .write_psum_ctrl(write_psum_ctrl),
    .read_req_psum(read_req_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef CLUS_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  clus_ctrl #(.W_GLB_BASE(WB2)) dut_wrap (
    .clk(clk), .reset(reset), .job_start(job_start), .busy(busy_b), .job_done(job_done_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .write_en_wght(write_en_wght_b), .w_addr_wght(w_addr_wght_b), .w_data_wght(w_data_wght_b),
    .write_en_iact(write_en_iact_b), .w_addr_iact(w_addr_iact_b), .w_data_iact(w_data_iact_b),
    .load_spad_ctrl_wght(load_spad_ctrl_wght_b), .load_spad_ctrl_iact(load_spad_ctrl_iact_b),
    .load_done_wght(load_done_wght), .load_done_iact(load_done_iact),
    .start(start_b), .write_psum_ctrl(write_psum_ctrl),
    .read_req_psum(read_req_psum_b), .r_addr_psum(r_addr_psum_b), .r_data_psum(r_data_psum),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
`ifdef CLUS_CTRL_PERF_EN
    , .perf_cycles(perf_cycles_b)
`endif
  );

  // GLB psum memory model: registered read, data one cycle after request.
  logic [DW-1:0] psum_mem [0:1023];
  always @(posedge clk) begin
    if (read_req_psum) r_data_psum <= psum_mem[r_addr_psum];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] words [0:NW+NA-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, job_done, in_ready, write_en_wght, write_en_iact,
                              load_spad_ctrl_wght, load_spad_ctrl_iact, start,
                              read_req_psum, out_valid}), 64'd0);
    check({tag, "_wr"}, 64'({w_addr_wght, w_data_wght, w_addr_iact, w_data_iact}), 64'd0);
    check({tag, "_rd"}, 64'({r_addr_psum, out_data}), 64'd0);
  endtask

  // One layer job. abort_at >= 0 asserts reset once that many iact words
  // have been accepted.
  task automatic run_job(input bit gaps, input bit stalls, input bit early_ldw,
                         input bit poke_start, input int abort_at);
    int k = 0, wi = 0, ii = 0, ri = 0, oi = 0, wi2 = 0;
    int ldw_n = 0, ldi_n = 0, st_n = 0, dn_n = 0, busy_n = 0;
    int since_start = -1, wp_cyc = -1, done_cyc = -1;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_od = '0;
    for (int i = 0; i < NW + NA; i++) words[i] = DW'($urandom);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && k == NW + abort_at) begin
        reset = 1'b1; in_valid = 1'b0; job_start = 1'b0;
        load_done_wght = 1'b0; load_done_iact = 1'b0; write_psum_ctrl = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        @(negedge clk);
        check_all_zero("abort_hold");
        return;
      end
      job_start       = (cyc == 0) || (poke_start && since_start == 20);
      if (k < NW + NA) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = words[k];
      end else begin
        in_valid = ($urandom_range(0, 1) != 0);
        in_data  = DW'($urandom);
      end
      load_done_wght  = early_ldw ? 1'b1 : (ldw_n == 5);
      load_done_iact  = (ldi_n == 5);
      write_psum_ctrl = (since_start == 50);
      if (write_psum_ctrl) wp_cyc = cyc;
      out_ready       = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;

      @(negedge clk);
      if (cyc == 1) check("busy_after_accept", 64'(busy), 64'd1);
      if (in_valid && in_ready) k++;
      if (write_en_wght) begin
        check("wght_addr", 64'(w_addr_wght), 64'((0 + wi) % 1024));
        check("wght_data", 64'(w_data_wght), 64'(words[wi]));
        wi++;
      end
      if (write_en_iact) begin
        check("iact_addr", 64'(w_addr_iact), 64'((0 + ii) % 1024));
        check("iact_data", 64'(w_data_iact), 64'(words[NW + ii]));
        ii++;
      end
      if (write_en_wght_b) begin
        check("wght_addr_wrap", 64'(w_addr_wght_b), 64'((WB2 + wi2) % 1024));
        wi2++;
      end
      if (load_spad_ctrl_wght) ldw_n++;
      if (load_spad_ctrl_iact) ldi_n++;
      if (start) begin
        st_n++;
        since_start = 0;
      end else if (since_start >= 0) begin
        since_start++;
      end
      if (read_req_psum) begin
        if (ri == 0) check("drain_latency", 64'(cyc - wp_cyc), 64'(DRAIN + 3));
        check("psum_raddr", 64'(r_addr_psum), 64'((0 + ri) % 1024));
        ri++;
      end
      if (prev_stall) begin
        check("out_hold_valid", 64'(out_valid), 64'd1);
        check("out_hold_data", 64'(out_data), 64'(prev_od));
      end
      prev_stall = out_valid && !out_ready;
      prev_od    = out_data;
      if (out_valid && out_ready) begin
        check("psum_out", 64'(out_data), 64'(psum_mem[oi]));
        oi++;
      end
      if (busy) busy_n++;
      if (job_done) begin
        dn_n++;
        done_cyc = cyc;
        check("busy_at_done", 64'(busy), 64'd0);
        check("words_at_done", 64'(oi), 64'(NP));
      end else if (dn_n > 0) begin
        check("idle_after_done", 64'(busy), 64'd0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end

    in_valid = 1'b0; load_done_wght = 1'b0; load_done_iact = 1'b0;
    write_psum_ctrl = 1'b0; job_start = 1'b0;
    check("n_wght_writes", 64'(wi), 64'(NW));
    check("n_wght_writes_wrap", 64'(wi2), 64'(NW));
    check("n_iact_writes", 64'(ii), 64'(NA));
    check("n_ldw_cycles", 64'(ldw_n), early_ldw ? 64'd1 : 64'd6);
    check("n_ldi_cycles", 64'(ldi_n), 64'd6);
    check("n_start", 64'(st_n), 64'd1);
    check("n_reads", 64'(ri), 64'(NP));
    check("n_out", 64'(oi), 64'(NP));
    check("n_job_done", 64'(dn_n), 64'd1);
`ifdef CLUS_CTRL_PERF_EN
    check("perf_cycles", 64'(perf_cycles), 64'(busy_n));
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) psum_mem[i] = DW'($urandom);
    reset = 1'b1; job_start = 1'b0; in_valid = 1'b0; in_data = '0;
    load_done_wght = 1'b0; load_done_iact = 1'b0; write_psum_ctrl = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(1'b0, 1'b0, 1'b0, 1'b0, -1);  // nominal
    run_job(1'b1, 1'b1, 1'b0, 1'b0, -1);  // input gaps, output stalls
    run_job(1'b0, 1'b1, 1'b1, 1'b0, -1);  // load_done_wght high on entry
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 40);  // reset mid-LOAD_I
    run_job(1'b0, 1'b0, 1'b0, 1'b0, -1);  // restart after abort
    run_job(1'b1, 1'b1, 1'b0, 1'b1, -1);  // job_start during COMPUTE

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
